// File: rtl/instruction_fetcher.sv
// Fetch unit: holds the fetch PC, looks it up in a direct-mapped one-word-per-line
// instruction cache, refills misses from memory and pushes {instruction, pc} to the queue.
module instruction_fetcher #(
   parameter int unsigned ICACHE_INDEX_BITS = 4,
   parameter logic [31:0] RESET_PC          = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        roll_back,
   input  logic [31:0] roll_back_pc,
   input  logic        isq_is_full,
   output logic        instruction_ready,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);

   localparam int unsigned LINES = 1 << ICACHE_INDEX_BITS;
   localparam int unsigned TAG_W = 32 - ICACHE_INDEX_BITS - 2;
   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

   typedef enum logic {
      RUN,
      MEM
   } state_t;

   state_t                       state;
   logic [31:0]                  pc;
   logic [LINES-1:0]             valid;
   logic [TAG_W-1:0]             tag_mem  [LINES];
   logic [31:0]                  data_mem [LINES];

   logic [ICACHE_INDEX_BITS-1:0] pc_idx;
   logic [ICACHE_INDEX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]             pc_tag;
   logic [TAG_W-1:0]             fill_tag;
   logic                         hit;
   logic                         fill;

   // Lookup uses the live fetch PC; refills are addressed by the outstanding request.
   assign pc_idx   = pc[ICACHE_INDEX_BITS+1:2];
   assign pc_tag   = pc[31:ICACHE_INDEX_BITS+2];
   assign fill_idx = mem_addr[ICACHE_INDEX_BITS+1:2];
   assign fill_tag = mem_addr[31:ICACHE_INDEX_BITS+2];
   assign hit      = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign fill     = (state == MEM) && mem_done;

   // Tag and data arrays need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk_in) begin
      if (fill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_data;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state             <= RUN;
         pc                <= RESET_PC_W;
         valid             <= '0;
         instruction_ready <= 1'b0;
         instruction_out   <= 32'h0;
         pc_out            <= 32'h0;
         mem_req           <= 1'b0;
         mem_addr          <= 32'h0;
      end else begin
         instruction_ready <= 1'b0;

         // A response is always absorbed, even while paused or being redirected.
         if (fill) begin
            valid[fill_idx] <= 1'b1;
            mem_req         <= 1'b0;
            state           <= RUN;
         end

         if (roll_back) begin
            pc <= {roll_back_pc[31:2], 2'b00};
         end else if (rdy_in && (state == RUN)) begin
            if (hit) begin
               if (!isq_is_full) begin
                  instruction_ready <= 1'b1;
                  instruction_out   <= data_mem[pc_idx];
                  pc_out            <= pc;
                  pc                <= pc + 32'd4;
               end
            end else begin
               mem_req  <= 1'b1;
               mem_addr <= pc;
               state    <= MEM;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_instruction_fetcher;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        roll_back;
   logic [31:0] roll_back_pc;
   logic        isq_is_full;
   logic        instruction_ready;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;

   int n_checks = 0;
   int n_pass   = 0;
   int mem_lat  = 3;

   instruction_fetcher #(.ICACHE_INDEX_BITS(4), .RESET_PC(32'h0)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .roll_back         (roll_back),
      .roll_back_pc      (roll_back_pc),
      .isq_is_full       (isq_is_full),
      .instruction_ready (instruction_ready),
      .instruction_out   (instruction_out),
      .pc_out            (pc_out),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_done          (mem_done),
      .mem_data          (mem_data)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 8) | 32'h13;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [16];
   logic [31:0] m_line  [16];
   logic [31:0] m_word  [16];
   logic [31:0] m_pc, m_addr, m_out, m_pcout;
   bit          m_wait, m_req, m_ready;

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % 32'd16);
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_addr = 32'h0; m_out = 32'h0; m_pcout = 32'h0;
      m_wait = 0; m_req = 0; m_ready = 0;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
   endtask

   task automatic model_step();
      bit was_wait;
      int i;
      was_wait = m_wait;
      m_ready  = 0;
      if (m_wait && mem_done) begin
         i = line_of(m_addr);
         m_valid[i] = 1; m_line[i] = m_addr; m_word[i] = mem_data;
         m_wait = 0; m_req = 0;
      end
      if (roll_back) begin
         m_pc = roll_back_pc & ~32'h3;
      end else if (rdy_in && !was_wait) begin
         i = line_of(m_pc);
         if (m_valid[i] && m_line[i] == m_pc) begin
            if (!isq_is_full) begin
               m_ready = 1; m_out = m_word[i]; m_pcout = m_pc; m_pc = m_pc + 32'd4;
            end
         end else begin
            m_wait = 1; m_req = 1; m_addr = m_pc;
         end
      end
   endtask

   // Compare process: advance the model at each edge, check outputs just after it.
   initial begin
      forever begin
         @(posedge clk_in);
         if (rst_in) model_reset();
         else model_step();
         #1;
         check("cmp_ready", 32'(instruction_ready), 32'(m_ready));
         check("cmp_instr", instruction_out, m_out);
         check("cmp_pc_out", pc_out, m_pcout);
         check("cmp_mem_req", 32'(mem_req), 32'(m_req));
         check("cmp_mem_addr", mem_addr, m_addr);
      end
   end

   // Memory responder: mem_lat cycles after seeing a request (0 = random 1..5).
   initial begin
      bit busy;
      int cnt;
      busy = 0; cnt = 0; mem_done = 1'b0; mem_data = 32'h0;
      forever begin
         @(negedge clk_in);
         mem_done = 1'b0;
         mem_data = $urandom;
         if (rst_in) begin
            busy = 0;
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               mem_done = 1'b1;
               mem_data = mem_word(mem_addr);
               busy = 0;
            end
         end else if (mem_req) begin
            busy = 1;
            cnt  = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 5));
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic do_rollback(input logic [31:0] pc);
      roll_back = 1'b1; roll_back_pc = pc;
      @(negedge clk_in);
      roll_back = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i <= budget; i++) begin
         if (mem_req) begin ok = 1; break; end
         @(negedge clk_in);
      end
   endtask

   task automatic wait_pulse(input int budget, output bit ok, output bit saw_req);
      ok = 0; saw_req = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (mem_req) saw_req = 1;
         if (instruction_ready) begin ok = 1; break; end
      end
   endtask

   task automatic wait_pulse_pc(input logic [31:0] pc, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (instruction_ready && pc_out == pc) begin ok = 1; break; end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      bit ok, saw, held, pulsed;
      rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; roll_back_pc = 32'h0; isq_is_full = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_ready", 32'(instruction_ready), 32'd0);
      check("rst_instr", instruction_out, 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      rst_in = 1'b0;

      // First fetch from RESET_PC
      wait_req(20, ok);           check("t1_req_seen", 32'(ok), 32'd1);
      check("t1_req_addr", mem_addr, 32'h0);
      wait_pulse(20, ok, saw);    check("t1_pulse_seen", 32'(ok), 32'd1);
      check("t1_instr", instruction_out, 32'h13);
      check("t1_pc", pc_out, 32'h0);
      wait_req(5, ok);            check("t1_req2_seen", 32'(ok), 32'd1);
      check("t1_req2_addr", mem_addr, 32'h4);

      // Back-to-back hits after redirect to cached lines
      mem_lat = 0;
      wait_pulse_pc(32'hc, 100, ok); check("t2_fill_12", 32'(ok), 32'd1);
      do_rollback(32'h0);
      for (int k = 0; k < 4; k++) begin
         wait_pulse(1, ok, saw);
         check("t2_pulse_seen", 32'(ok), 32'd1);
         check("t2_pulse_pc", pc_out, 32'(k * 4));
         check("t2_instr", instruction_out, mem_word(32'(k * 4)));
         check("t2_no_req", 32'(saw), 32'd0);
      end
      wait_req(3, ok);            check("t2_req_seen", 32'(ok), 32'd1);
      check("t2_req_addr", mem_addr, 32'h10);

      // Queue full freezes the PC
      wait_pulse_pc(32'h10, 30, ok); check("t3_pulse16", 32'(ok), 32'd1);
      isq_is_full = 1'b1;
      do_rollback(32'h4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_in);
         check("t3_full_no_pulse", 32'(instruction_ready), 32'd0);
      end
      isq_is_full = 1'b0;
      wait_pulse(2, ok, saw);     check("t3_release_seen", 32'(ok), 32'd1);
      check("t3_release_pc", pc_out, 32'h4);

      // Redirect while a request is outstanding
      mem_lat = 8;
      do_rollback(32'h20);
      wait_req(5, ok);            check("t4_req_seen", 32'(ok), 32'd1);
      check("t4_req_addr", mem_addr, 32'h20);
      do_rollback(32'h100);
      held = 1; pulsed = 0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_req) break;
         if (mem_addr != 32'h20) held = 0;
         if (instruction_ready) pulsed = 1;
         @(negedge clk_in);
      end
      check("t4_req_dropped", 32'(mem_req), 32'd0);
      check("t4_req_held", 32'(held), 32'd1);
      check("t4_no_pulse", 32'(pulsed | instruction_ready), 32'd0);
      wait_req(3, ok);            check("t4_req2_seen", 32'(ok), 32'd1);
      check("t4_req2_addr", mem_addr, 32'h100);
      mem_lat = 2;
      wait_pulse_pc(32'h100, 20, ok); check("t4_pulse100", 32'(ok), 32'd1);
      do_rollback(32'h20);
      wait_pulse(1, ok, saw);     check("t4_hit20_seen", 32'(ok), 32'd1);
      check("t4_hit20_pc", pc_out, 32'h20);
      check("t4_hit20_instr", instruction_out, mem_word(32'h20));
      check("t4_hit20_no_req", 32'(saw), 32'd0);

      // Conflict miss on a shared line
      do_rollback(32'h0);
      wait_pulse_pc(32'h0, 20, ok); check("t5_pulse0", 32'(ok), 32'd1);
      do_rollback(32'h40);
      wait_req(3, ok);            check("t5_req40_seen", 32'(ok), 32'd1);
      check("t5_req40_addr", mem_addr, 32'h40);
      wait_pulse_pc(32'h40, 20, ok); check("t5_pulse40", 32'(ok), 32'd1);
      do_rollback(32'h0);
      wait_req(3, ok);            check("t5_req0_seen", 32'(ok), 32'd1);
      check("t5_req0_addr", mem_addr, 32'h0);

      // Pause over hits, and a response absorbed while paused
      wait_pulse_pc(32'h0, 20, ok); check("t6_pulse0", 32'(ok), 32'd1);
      rdy_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         check("t6_paused_no_pulse", 32'(instruction_ready), 32'd0);
      end
      rdy_in = 1'b1;
      wait_pulse(1, ok, saw);     check("t6_resume_seen", 32'(ok), 32'd1);
      check("t6_resume_pc", pc_out, 32'h4);
      wait_req(10, ok);           check("t6_req_seen", 32'(ok), 32'd1);
      check("t6_req_addr", mem_addr, 32'h14);
      rdy_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!mem_req) break;
         @(negedge clk_in);
      end
      check("t6_done_while_paused", 32'(mem_req), 32'd0);
      repeat (2) @(negedge clk_in);
      check("t6_no_new_req", 32'(mem_req), 32'd0);
      rdy_in = 1'b1;

      // Asynchronous reset in the middle of a miss
      mem_lat = 8;
      wait_pulse_pc(32'h14, 10, ok); check("t7_pulse14", 32'(ok), 32'd1);
      wait_req(3, ok);            check("t7_req_seen", 32'(ok), 32'd1);
      check("t7_req_addr", mem_addr, 32'h18);
      rst_in = 1'b1;
      #1;
      check("t7_async_req", 32'(mem_req), 32'd0);
      check("t7_async_ready", 32'(instruction_ready), 32'd0);
      check("t7_async_pc_out", pc_out, 32'h0);
      check("t7_async_addr", mem_addr, 32'h0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      wait_req(5, ok);            check("t7_refetch_seen", 32'(ok), 32'd1);
      check("t7_refetch_addr", mem_addr, 32'h0);

      // Randomized traffic against the model
      mem_lat = 0;
      repeat (3000) begin
         @(negedge clk_in);
         roll_back    = ($urandom_range(0, 11) == 0);
         roll_back_pc = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 + 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 383));
         isq_is_full  = ($urandom_range(0, 3) == 0);
         rdy_in       = ($urandom_range(0, 5) != 0);
      end
      @(negedge clk_in);
      roll_back = 1'b0; isq_is_full = 1'b0; rdy_in = 1'b1;
      repeat (20) @(negedge clk_in);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
